// File: rtl/seq_det_pkg.sv
// seq_det_pkg
//   Shared types and constants for the 1011 sequence-detector scheduler.
//   - arb_state_t : scheduler FSM states (IDLE, LOAD, SHIFT, FLUSH, REPORT)
//   - det_state_t : Moore detector states (S0..S4, S4 = pattern seen)
//   - PATTERN     : the detected bit pattern, consumed MSB first
//   Configuration macro: SEQ_DET_OVERLAP_EN (used by seq_det_moore only).
package seq_det_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SHIFT  = 3'd2,
    FLUSH  = 3'd3,
    REPORT = 3'd4
  } arb_state_t;

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } det_state_t;

  localparam logic [3:0] PATTERN = 4'b1011;

endpackage

// File: rtl/seq_det_moore.sv
// seq_det_moore
//   Serial Moore detector for PATTERN (1011), one bit per clock.
//   Ports:
//     clk   in  : rising-edge clock
//     reset in  : asynchronous, active-low clear to S0
//     clr   in  : synchronous clear to S0 (start of a new word)
//     x     in  : serial input bit
//     z     out : high only while the registered state is S4
//   Configuration macro: SEQ_DET_OVERLAP_EN
//     defined   : overlapping mode, from S4 a 0 resumes at S2 ("10" seen)
//     undefined : non-overlapping mode, from S4 a 0 restarts at S0
module seq_det_moore
  import seq_det_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic x,
  output logic z
);

  det_state_t state;
  det_state_t state_nxt;

  // Next-state logic. Each state Sk has matched the first k pattern bits and
  // compares x with the next expected bit; a mismatch falls back to the
  // longest prefix of 1011 that is still a suffix of what was seen.
  always_comb begin
    state_nxt = state;
    case (state)
      S0: state_nxt = (x == PATTERN[3]) ? S1 : S0;
      S1: state_nxt = (x == PATTERN[2]) ? S2 : S1;
      S2: state_nxt = (x == PATTERN[1]) ? S3 : S0;
      S3: state_nxt = (x == PATTERN[0]) ? S4 : S2;
      S4: begin
`ifdef SEQ_DET_OVERLAP_EN
        // The trailing 1 of the match doubles as the first pattern bit.
        state_nxt = (x == PATTERN[3]) ? S1 : S2;
`else
        state_nxt = (x == PATTERN[3]) ? S1 : S0;
`endif
      end
      default: state_nxt = S0;
    endcase
  end

  // State register; clr restarts detection at the start of every word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S0;
    end else if (clr) begin
      state <= S0;
    end else begin
      state <= state_nxt;
    end
  end

  assign z = (state == S4);

endmodule

// File: rtl/seq_det_arbiter.sv
// seq_det_arbiter
//   Round-robin scheduler sharing one 1011 Moore detector among N_REQ
//   requesters. The winner's W-bit word is shifted MSB first through the
//   detector, matches are counted (saturating), and the count is reported
//   with a one-cycle done pulse tagged with the requester index.
//   Parameters: N_REQ (>=2), W (>=4), CNT_W (match counter width)
//   Ports:
//     clk       in  : rising-edge clock
//     reset     in  : asynchronous, active-low
//     req       in  : per-requester level request
//     data      in  : requester i word at data[i*W +: W]
//     gnt       out : one-hot grant, LOAD through FLUSH
//     busy      out : high outside IDLE
//     done      out : one-cycle pulse in REPORT
//     done_id   out : served requester index
//     match_cnt out : matches found in the served word
//     det_z     out : detector Moore output
//   Configuration macro: SEQ_DET_OVERLAP_EN (selects overlapping detection
//   inside seq_det_moore; nothing else here changes).
module seq_det_arbiter
  import seq_det_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W     = 8,
  parameter int CNT_W = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*W-1:0]       data,
  output logic [N_REQ-1:0]         gnt,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(N_REQ)-1:0] done_id,
  output logic [CNT_W-1:0]         match_cnt,
  output logic                     det_z
);

  localparam int IDW = $clog2(N_REQ);
  localparam int BCW = $clog2(W);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  arb_state_t     state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] served_id;
  logic [IDW-1:0] sel_id;
  logic [IDW-1:0] cand;
  logic           sel_valid;
  logic [W-1:0]   shreg;
  logic [BCW-1:0] bit_cnt;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]   words [N_REQ];
  logic           det_clr;
  logic           det_x;
  logic           z;

  // Split the flat data bus into one word per requester.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      words[i] = data[i*W +: W];
    end
  end

  // Round-robin search: the requester just after the last winner has the
  // highest priority, and the last winner itself is checked last, so a
  // requester that keeps req high only regains the grant when nobody else
  // is waiting.
  always_comb begin
    sel_valid = 1'b0;
    sel_id    = '0;
    cand      = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = IDW'((int'(ptr) + i) % N_REQ);
      if (!sel_valid && req[cand]) begin
        sel_valid = 1'b1;
        sel_id    = cand;
      end
    end
  end

  // Scheduler FSM with its datapath. The shift register feeds zeros in from
  // the bottom, so once a word has been shifted out the detector only ever
  // sees 0 outside SHIFT and cannot raise a stray match. The match counter
  // samples z in SHIFT and FLUSH; FLUSH is what catches a match completed by
  // the last bit, since z trails the input by one clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ptr       <= IDW'(N_REQ - 1);
      served_id <= '0;
      shreg     <= '0;
      bit_cnt   <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_valid) begin
            ptr       <= sel_id;
            served_id <= sel_id;
            state     <= LOAD;
          end
        end
        LOAD: begin
          shreg   <= words[served_id];
          bit_cnt <= '0;
          cnt     <= '0;
          state   <= SHIFT;
        end
        SHIFT: begin
          shreg   <= {shreg[W-2:0], 1'b0};
          bit_cnt <= bit_cnt + 1'b1;
          if (z && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
          end
          if (bit_cnt == BCW'(W - 1)) begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          if (z && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
          end
          state <= REPORT;
        end
        REPORT: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // The detector is restarted while the word is being loaded.
  assign det_clr = (state == LOAD);
  assign det_x   = shreg[W-1];

  seq_det_moore u_det (
    .clk   (clk),
    .reset (reset),
    .clr   (det_clr),
    .x     (det_x),
    .z     (z)
  );

  // Grant is decoded from the served index while a word is in flight.
  always_comb begin
    gnt = '0;
    if ((state == LOAD) || (state == SHIFT) || (state == FLUSH)) begin
      gnt[served_id] = 1'b1;
    end
  end

  assign busy      = (state != IDLE);
  assign done      = (state == REPORT);
  assign done_id   = served_id;
  assign match_cnt = cnt;
  assign det_z     = z;

endmodule

// File: tb/tb_seq_det_arbiter.sv
// tb_seq_det_arbiter
//   Self-checking bench for seq_det_arbiter (N_REQ=4, W=8, CNT_W=4) plus a
//   second instance with CNT_W=1 for counter saturation. Expected results
//   come from a reference model (substring counting + round-robin pick),
//   pushed into a queue and popped by an independent done monitor.
//   Honours SEQ_DET_OVERLAP_EN the same way as the design.
module tb_seq_det_arbiter;

  localparam int N_REQ = 4;
  localparam int W     = 8;
  localparam int CNT_W = 4;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic [N_REQ-1:0]   req = '0;
  logic [N_REQ*W-1:0] data = '0;
  logic [N_REQ-1:0]   gnt;
  logic               busy;
  logic               done;
  logic [1:0]         done_id;
  logic [CNT_W-1:0]   match_cnt;
  logic               det_z;

  logic [N_REQ-1:0]   req_s = '0;
  logic [N_REQ*W-1:0] data_s = '0;
  logic [N_REQ-1:0]   gnt_s;
  logic               busy_s;
  logic               done_s;
  logic [1:0]         done_id_s;
  logic [0:0]         match_cnt_s;
  logic               det_z_s;

  typedef struct {
    int id;
    int cnt;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;
  int   model_ptr = N_REQ - 1;

  seq_det_arbiter #(.N_REQ(N_REQ), .W(W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .data      (data),
    .gnt       (gnt),
    .busy      (busy),
    .done      (done),
    .done_id   (done_id),
    .match_cnt (match_cnt),
    .det_z     (det_z)
  );

  seq_det_arbiter #(.N_REQ(N_REQ), .W(W), .CNT_W(1)) dut_sat (
    .clk       (clk),
    .reset     (reset),
    .req       (req_s),
    .data      (data_s),
    .gnt       (gnt_s),
    .busy      (busy_s),
    .done      (done_s),
    .done_id   (done_id_s),
    .match_cnt (match_cnt_s),
    .det_z     (det_z_s)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // One comparison: counted, and reported on a FAIL line if it differs.
  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Reference count of 1011 in a word read MSB first, saturated to cw bits.
  function automatic int refCount(input logic [W-1:0] word, input int cw);
    int n;
    int i;
    int limit;
    n = 0;
    i = W - 1;
    while (i >= 3) begin
      if (word[i -: 4] == 4'b1011) begin
        n++;
`ifdef SEQ_DET_OVERLAP_EN
        i -= 1;
`else
        i -= 4;
`endif
      end else begin
        i -= 1;
      end
    end
    limit = (1 << cw) - 1;
    return (n > limit) ? limit : n;
  endfunction

  // Reference round-robin pick: first requester after p, wrapping around.
  function automatic int pickWinner(input logic [N_REQ-1:0] mask, input int p);
    for (int k = 1; k <= N_REQ; k++) begin
      if (mask[(p + k) % N_REQ]) return (p + k) % N_REQ;
    end
    return -1;
  endfunction

  // Holds req/data for a number of services, queues the model's predictions
  // and checks grant, latency to the first done and spacing of later dones.
  task automatic applyStimulus(input logic [N_REQ-1:0] mask,
                               input logic [N_REQ*W-1:0] words,
                               input int services);
    exp_t e;
    int   w;
    int   first_w;
    int   gap;
    @(posedge clk);
    #1;
    req  = mask;
    data = words;
    first_w = pickWinner(mask, model_ptr);
    for (int s = 0; s < services; s++) begin
      w = pickWinner(mask, model_ptr);
      model_ptr = w;
      e.id  = w;
      e.cnt = refCount(words[w*W +: W], CNT_W);
      expq.push_back(e);
    end
    for (int s = 0; s < services; s++) begin
      gap = 0;
      do begin
        @(posedge clk);
        #1;
        gap++;
        if (s == 0 && gap == 1) begin
          checkOutput("gnt_first", int'(gnt), 1 << first_w);
          checkOutput("busy_first", int'(busy), 1);
        end
      end while (done !== 1'b1 && gap < 40);
      checkOutput((s == 0) ? "latency" : "period", gap, (s == 0) ? 11 : 12);
      if (s == services - 1) req = '0;
    end
  endtask

  // Asserts reset across two edges and resets the model pointer with it.
  task automatic doReset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    req   = '0;
    model_ptr = N_REQ - 1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Monitor: every done pulse must match the oldest queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_done actual=done_id %0d expected=no done", done_id);
        end else begin
          e = expq.pop_front();
          checkOutput("done_id", int'(done_id), e.id);
          checkOutput("match_cnt", int'(match_cnt), e.cnt);
        end
      end
    end
  end

  // Directed cases followed by randomized service rounds.
  initial begin
    logic [N_REQ*W-1:0] wv;
    logic [N_REQ-1:0]   mask;
    int gap;

    // Reset held low with every requester asking.
    req = '1;
    req_s = '1;
    data = '1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput("rst_gnt", int'(gnt), 0);
      checkOutput("rst_busy", int'(busy), 0);
      checkOutput("rst_done", int'(done), 0);
      checkOutput("rst_match_cnt", int'(match_cnt), 0);
      checkOutput("rst_det_z", int'(det_z), 0);
      checkOutput("rst_sat_busy", int'(busy_s), 0);
      checkOutput("rst_sat_det_z", int'(det_z_s), 0);
    end
    @(posedge clk);
    #1;
    req = '0;
    req_s = '0;
    reset = 1'b1;

    // Single request from requester 2.
    wv = '0;
    wv[2*W +: W] = 8'b10111011;
    applyStimulus(4'b0100, wv, 1);

    // Requester 0 with a word whose count depends on overlap mode.
    wv = '0;
    wv[0 +: W] = 8'b10110110;
    applyStimulus(4'b0001, wv, 1);

    // All four held: order 0,1,2,3 twice, 12 cycles between dones.
    doReset();
    wv[0*W +: W] = 8'b00000000;
    wv[1*W +: W] = 8'b10110000;
    wv[2*W +: W] = 8'b10111011;
    wv[3*W +: W] = 8'b11111111;
    applyStimulus(4'b1111, wv, 8);

    // Reset in the middle of requester 1's SHIFT.
    doReset();
    @(posedge clk);
    #1;
    wv = '0;
    wv[1*W +: W] = 8'b10111011;
    data = wv;
    req  = 4'b0010;
    repeat (7) @(posedge clk);
    #1;
    checkOutput("mid_gnt", int'(gnt), 2);
    checkOutput("mid_match_cnt", int'(match_cnt), 1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("abort_gnt", int'(gnt), 0);
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_done", int'(done), 0);
    checkOutput("abort_match_cnt", int'(match_cnt), 0);
    checkOutput("abort_det_z", int'(det_z), 0);
    model_ptr = N_REQ - 1;
    req = '0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    applyStimulus(4'b0011, wv, 1);

    // Randomized rounds against the reference model.
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < N_REQ; i++) wv[i*W +: W] = W'($urandom);
      if ($urandom_range(0, 1) == 1) wv[$urandom_range(0, N_REQ-1)*W +: W] = 8'b10111011;
      mask = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
      applyStimulus(mask, wv, $urandom_range(1, 4));
    end

    // Saturating counter instance: two matches clamp to 1.
    @(posedge clk);
    #1;
    wv = '0;
    wv[0 +: W] = 8'b10111011;
    data_s = wv;
    req_s  = 4'b0001;
    @(posedge clk);
    #1;
    checkOutput("sat_gnt", int'(gnt_s), 1);
    gap = 1;
    while (done_s !== 1'b1 && gap < 40) begin
      @(posedge clk);
      #1;
      gap++;
    end
    req_s = '0;
    checkOutput("sat_latency", gap, 11);
    checkOutput("sat_match_cnt", int'(match_cnt_s), refCount(wv[0 +: W], 1));
    checkOutput("sat_done_id", int'(done_id_s), 0);

    repeat (4) @(posedge clk);
    checkOutput("queue_drained", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
